// File: rtl/rvsteel_reset_ctrl_pkg.sv
// Shared types for the rvsteel reset/halt sequencer: FSM state encoding, reset cause codes
// and a counter-width helper.
package rvsteel_reset_ctrl_pkg;

   typedef enum logic [1:0] {
      POR    = 2'd0,
      ASSERT = 2'd1,
      HOLD   = 2'd2,
      RUN    = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      CAUSE_POR    = 2'd0,
      CAUSE_BUTTON = 2'd1,
      CAUSE_WDT    = 2'd2
   } cause_t;

   // Width able to hold 0..value-1, never narrower than one bit.
   function automatic int clog2_min1(input int value);
      return (value <= 2) ? 1 : $clog2(value);
   endfunction

endpackage

// File: rtl/rvsteel_reset_halt_controller_if.sv
// Button inputs and core-control outputs of the reset/halt sequencer.
// The board side uses master, the controller uses slave.
interface rvsteel_reset_halt_controller_if;

   logic       reset_button;
   logic       halt_button;
   logic       wdt_kick;
   logic       core_reset;
   logic       core_halt;
   logic [1:0] reset_cause;

   modport master (
      output reset_button, halt_button, wdt_kick,
      input  core_reset, core_halt, reset_cause
   );

   modport slave (
      input  reset_button, halt_button, wdt_kick,
      output core_reset, core_halt, reset_cause
   );

endinterface

// File: rtl/rvsteel_button_debouncer.sv
// Two-flop synchronizer plus debounce counter for one raw push-button; emits a 1-cycle
// press pulse on each accepted rising level.
module rvsteel_button_debouncer
   import rvsteel_reset_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 120000
) (
   input  logic clock,
   input  logic reset_n,
   input  logic button,
   output logic level,
   output logic press
);

   localparam int CNT_W = clog2_min1(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [1:0]       sync_ff;
   logic [CNT_W-1:0] stable_count;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sync_ff <= 2'b00;
      end else begin
         sync_ff <= {sync_ff[0], button};
      end
   end

   // Any cycle back at the accepted level restarts the count of differing cycles.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         level        <= 1'b0;
         press        <= 1'b0;
         stable_count <= '0;
      end else if (sync_ff[1] == level) begin
         press        <= 1'b0;
         stable_count <= '0;
      end else if (stable_count == CNT_LAST) begin
         level        <= sync_ff[1];
         press        <= sync_ff[1];
         stable_count <= '0;
      end else begin
         press        <= 1'b0;
         stable_count <= stable_count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/rvsteel_reset_halt_controller.sv
// Reset/halt sequencer for the rvsteel core: POR stretch, debounced reset button with hold-off,
// halt toggle. Optional watchdog enabled by defining RVSTEEL_RESET_CTRL_WATCHDOG_EN.
module rvsteel_reset_halt_controller
   import rvsteel_reset_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES   = 120000,
   parameter int POR_CYCLES        = 1024,
   parameter int RESET_HOLD_CYCLES = 16,
   parameter int WDT_CYCLES        = 12000000
) (
   input logic clock,
   input logic reset_n,
   rvsteel_reset_halt_controller_if.slave ctrl
);

   localparam int POR_W  = clog2_min1(POR_CYCLES);
   localparam int HOLD_W = clog2_min1(RESET_HOLD_CYCLES);
   localparam int CNT_W  = (POR_W > HOLD_W) ? POR_W : HOLD_W;
   localparam logic [CNT_W-1:0] POR_LAST  = CNT_W'(POR_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RESET_HOLD_CYCLES - 1);

   state_t           state;
   state_t           next_state;
   cause_t           cause_q;
   logic [CNT_W-1:0] state_count;
   logic             core_reset_q;
   logic             core_halt_q;
   logic             reset_level;
   logic             halt_press;
   logic             wdt_expire;
   logic             unused_reset_press;
   logic             unused_halt_level;

   rvsteel_button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_reset_debouncer (
      .clock   (clock),
      .reset_n (reset_n),
      .button  (ctrl.reset_button),
      .level   (reset_level),
      .press   (unused_reset_press)
   );

   rvsteel_button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_halt_debouncer (
      .clock   (clock),
      .reset_n (reset_n),
      .button  (ctrl.halt_button),
      .level   (unused_halt_level),
      .press   (halt_press)
   );

`ifdef RVSTEEL_RESET_CTRL_WATCHDOG_EN
   localparam int WDT_W = clog2_min1(WDT_CYCLES);
   localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_CYCLES - 1);

   logic [WDT_W-1:0] wdt_count;

   // A kick in the expiry cycle wins; the counter only advances while running unhalted.
   assign wdt_expire = (state == RUN) && !core_halt_q && !ctrl.wdt_kick && (wdt_count == WDT_LAST);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wdt_count <= '0;
      end else if ((state != RUN) || core_halt_q || ctrl.wdt_kick || wdt_expire) begin
         wdt_count <= '0;
      end else begin
         wdt_count <= wdt_count + WDT_W'(1);
      end
   end
`else
   localparam int unused_wdt_cycles = WDT_CYCLES;
   logic unused_wdt_kick;

   assign unused_wdt_kick = ctrl.wdt_kick;
   assign wdt_expire      = 1'b0;
`endif

   // The reset button is ignored during POR; it restarts the sequence from HOLD or RUN.
   always_comb begin
      next_state = state;
      case (state)
         POR:     if (state_count == POR_LAST) next_state = HOLD;
         ASSERT:  if (!reset_level) next_state = HOLD;
         HOLD: begin
            if (reset_level)                     next_state = ASSERT;
            else if (state_count == HOLD_LAST)   next_state = RUN;
         end
         RUN: begin
            if (reset_level)     next_state = ASSERT;
            else if (wdt_expire) next_state = HOLD;
         end
         default: next_state = POR;
      endcase
   end

   // Outputs follow next_state so core_reset and core_halt can never be high together.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state        <= POR;
         state_count  <= '0;
         core_reset_q <= 1'b1;
         core_halt_q  <= 1'b0;
         cause_q      <= CAUSE_POR;
      end else begin
         state        <= next_state;
         core_reset_q <= (next_state != RUN);

         if (next_state != state) begin
            state_count <= '0;
         end else if ((state == POR) || (state == HOLD)) begin
            state_count <= state_count + CNT_W'(1);
         end

         if (next_state != RUN) begin
            core_halt_q <= 1'b0;
         end else if ((state == RUN) && halt_press) begin
            core_halt_q <= ~core_halt_q;
         end

         if ((next_state == ASSERT) && (state != ASSERT)) begin
            cause_q <= CAUSE_BUTTON;
         end else if (wdt_expire) begin
            cause_q <= CAUSE_WDT;
         end
      end
   end

   assign ctrl.core_reset  = core_reset_q;
   assign ctrl.core_halt   = core_halt_q;
   assign ctrl.reset_cause = cause_q;

endmodule

// File: tb/tb_rvsteel_reset_halt_controller.sv
// Directed bench for rvsteel_reset_halt_controller with DEBOUNCE=5, POR=8, HOLD=4, WDT=20;
// the watchdog scenario follows RVSTEEL_RESET_CTRL_WATCHDOG_EN.
module tb_rvsteel_reset_halt_controller;

   logic clock     = 1'b0;
   logic reset_n   = 1'b0;
   logic auto_kick = 1'b1;
   logic manual_kick = 1'b0;
   int   kick_phase = 0;
   int   total = 0;
   int   bad   = 0;

   rvsteel_reset_halt_controller_if ctrl_if ();

   rvsteel_reset_halt_controller #(
      .DEBOUNCE_CYCLES   (5),
      .POR_CYCLES        (8),
      .RESET_HOLD_CYCLES (4),
      .WDT_CYCLES        (20)
   ) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .ctrl    (ctrl_if)
   );

   always #5 clock = ~clock;

   // Background kicker keeps a watchdog build from firing during the non-watchdog scenarios.
   initial begin
      ctrl_if.wdt_kick = 1'b0;
      forever begin
         @(negedge clock);
         #1;
         kick_phase = kick_phase + 1;
         ctrl_if.wdt_kick = manual_kick | (auto_kick & ((kick_phase % 8) == 0));
      end
   end

   initial begin
      #1000000;
      $display("[TB] FAIL global_timeout: simulation did not finish, expected finish before 1ms");
      $fatal(1, "[TB] timeout");
   end

   task automatic tick();
      @(negedge clock);
   endtask

   task automatic por_sequence(input string name);
      int n;
      @(negedge clock);
      reset_n = 1'b1;
      n = 0;
      while (ctrl_if.core_reset === 1'b1 && n < 100) begin
         tick();
         n++;
      end
      total++;
      if (n !== 12) begin
         bad++;
         $display("[TB] FAIL %s_por_length: got %0d cycles, expected 12", name, n);
      end
      total++;
      if (ctrl_if.reset_cause !== 2'b00) begin
         bad++;
         $display("[TB] FAIL %s_por_cause: got %b, expected 00", name, ctrl_if.reset_cause);
      end
      total++;
      if (ctrl_if.core_halt !== 1'b0) begin
         bad++;
         $display("[TB] FAIL %s_por_halt: got %b, expected 0", name, ctrl_if.core_halt);
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      ctrl_if.reset_button = 1'b0;
      ctrl_if.halt_button  = 1'b0;
      repeat (3) tick();
      total++;
      if (ctrl_if.core_reset !== 1'b1) begin
         bad++;
         $display("[TB] FAIL reset_core_reset: got %b, expected 1", ctrl_if.core_reset);
      end
      total++;
      if (ctrl_if.core_halt !== 1'b0) begin
         bad++;
         $display("[TB] FAIL reset_core_halt: got %b, expected 0", ctrl_if.core_halt);
      end
      total++;
      if (ctrl_if.reset_cause !== 2'b00) begin
         bad++;
         $display("[TB] FAIL reset_cause: got %b, expected 00", ctrl_if.reset_cause);
      end
      por_sequence("power_on");
   endtask

   task automatic test_reset_button();
      int   n;
      logic ok;
      ok = 1'b1;
      repeat (4) begin
         ctrl_if.reset_button = 1'b1;
         repeat (3) begin tick(); if (ctrl_if.core_reset !== 1'b0) ok = 1'b0; end
         ctrl_if.reset_button = 1'b0;
         repeat (2) begin tick(); if (ctrl_if.core_reset !== 1'b0) ok = 1'b0; end
      end
      repeat (8) begin tick(); if (ctrl_if.core_reset !== 1'b0) ok = 1'b0; end
      total++;
      if (ok !== 1'b1) begin
         bad++;
         $display("[TB] FAIL glitch_filter: core_reset rose on short pulses, expected to stay 0");
      end

      ctrl_if.reset_button = 1'b1;
      n = 0;
      while (ctrl_if.core_reset === 1'b0 && n < 30) begin tick(); n++; end
      total++;
      if (n !== 8) begin
         bad++;
         $display("[TB] FAIL button_assert_latency: got %0d cycles, expected 8", n);
      end
      total++;
      if (ctrl_if.reset_cause !== 2'b01) begin
         bad++;
         $display("[TB] FAIL button_cause: got %b, expected 01", ctrl_if.reset_cause);
      end
      repeat (10 - n) tick();
      ctrl_if.reset_button = 1'b0;
      n = 0;
      while (ctrl_if.core_reset === 1'b1 && n < 40) begin tick(); n++; end
      total++;
      if (n !== 12) begin
         bad++;
         $display("[TB] FAIL button_release_latency: got %0d cycles, expected 12", n);
      end
   endtask

   task automatic test_halt();
      ctrl_if.halt_button = 1'b1;
      repeat (7) tick();
      total++;
      if (ctrl_if.core_halt !== 1'b0) begin
         bad++;
         $display("[TB] FAIL halt_early: got %b, expected 0", ctrl_if.core_halt);
      end
      ctrl_if.halt_button = 1'b0;
      tick();
      total++;
      if (ctrl_if.core_halt !== 1'b1) begin
         bad++;
         $display("[TB] FAIL halt_toggle_on: got %b, expected 1", ctrl_if.core_halt);
      end
      repeat (10) tick();
      total++;
      if (ctrl_if.core_halt !== 1'b1) begin
         bad++;
         $display("[TB] FAIL halt_release_hold: got %b, expected 1", ctrl_if.core_halt);
      end
      ctrl_if.halt_button = 1'b1;
      repeat (7) tick();
      ctrl_if.halt_button = 1'b0;
      tick();
      total++;
      if (ctrl_if.core_halt !== 1'b0) begin
         bad++;
         $display("[TB] FAIL halt_toggle_off: got %b, expected 0", ctrl_if.core_halt);
      end
      repeat (10) tick();

      // Halt pulse lands in the second HOLD cycle after the reset button is released.
      ctrl_if.reset_button = 1'b1;
      repeat (10) tick();
      ctrl_if.reset_button = 1'b0;
      repeat (2) tick();
      ctrl_if.halt_button = 1'b1;
      repeat (7) tick();
      ctrl_if.halt_button = 1'b0;
      repeat (10) tick();
      total++;
      if (ctrl_if.core_reset !== 1'b0) begin
         bad++;
         $display("[TB] FAIL hold_back_to_run: got %b, expected 0", ctrl_if.core_reset);
      end
      total++;
      if (ctrl_if.core_halt !== 1'b0) begin
         bad++;
         $display("[TB] FAIL halt_in_hold_discarded: got %b, expected 0", ctrl_if.core_halt);
      end
   endtask

   task automatic test_simultaneous();
      int n;
      ctrl_if.halt_button = 1'b1;
      repeat (7) tick();
      ctrl_if.halt_button = 1'b0;
      tick();
      total++;
      if (ctrl_if.core_halt !== 1'b1) begin
         bad++;
         $display("[TB] FAIL sim_setup_halt: got %b, expected 1", ctrl_if.core_halt);
      end
      repeat (10) tick();
      ctrl_if.reset_button = 1'b1;
      ctrl_if.halt_button  = 1'b1;
      repeat (8) tick();
      total++;
      if (ctrl_if.core_reset !== 1'b1) begin
         bad++;
         $display("[TB] FAIL sim_reset_wins: got %b, expected 1", ctrl_if.core_reset);
      end
      total++;
      if (ctrl_if.core_halt !== 1'b0) begin
         bad++;
         $display("[TB] FAIL sim_halt_cleared: got %b, expected 0", ctrl_if.core_halt);
      end
      repeat (2) tick();
      ctrl_if.reset_button = 1'b0;
      ctrl_if.halt_button  = 1'b0;
      n = 0;
      while (ctrl_if.core_reset === 1'b1 && n < 40) begin tick(); n++; end
      repeat (10) tick();
      total++;
      if (ctrl_if.core_reset !== 1'b0) begin
         bad++;
         $display("[TB] FAIL sim_back_to_run: got %b, expected 0", ctrl_if.core_reset);
      end
      total++;
      if (ctrl_if.core_halt !== 1'b0) begin
         bad++;
         $display("[TB] FAIL sim_no_late_toggle: got %b, expected 0", ctrl_if.core_halt);
      end
   endtask

   task automatic test_watchdog();
      logic ok;
`ifdef RVSTEEL_RESET_CTRL_WATCHDOG_EN
      int n;
      auto_kick = 1'b0;
      ctrl_if.reset_button = 1'b1;
      repeat (10) tick();
      ctrl_if.reset_button = 1'b0;
      n = 0;
      while (ctrl_if.core_reset === 1'b1 && n < 40) begin tick(); n++; end
      n = 0;
      while (ctrl_if.core_reset === 1'b0 && n < 60) begin tick(); n++; end
      total++;
      if (n !== 20) begin
         bad++;
         $display("[TB] FAIL wdt_timeout: got %0d cycles, expected 20", n);
      end
      total++;
      if (ctrl_if.reset_cause !== 2'b10) begin
         bad++;
         $display("[TB] FAIL wdt_cause: got %b, expected 10", ctrl_if.reset_cause);
      end
      n = 0;
      while (ctrl_if.core_reset === 1'b1 && n < 40) begin tick(); n++; end
      ok = 1'b1;
      repeat (6) begin
         repeat (9) begin tick(); if (ctrl_if.core_reset !== 1'b0) ok = 1'b0; end
         manual_kick = 1'b1;
         tick();
         manual_kick = 1'b0;
         if (ctrl_if.core_reset !== 1'b0) ok = 1'b0;
      end
      total++;
      if (ok !== 1'b1) begin
         bad++;
         $display("[TB] FAIL wdt_kicked: core_reset rose, expected 0 throughout");
      end
      ctrl_if.halt_button = 1'b1;
      repeat (7) tick();
      ctrl_if.halt_button = 1'b0;
      tick();
      total++;
      if (ctrl_if.core_halt !== 1'b1) begin
         bad++;
         $display("[TB] FAIL wdt_halt_setup: got %b, expected 1", ctrl_if.core_halt);
      end
      ok = 1'b1;
      repeat (50) begin tick(); if (ctrl_if.core_reset !== 1'b0) ok = 1'b0; end
      total++;
      if (ok !== 1'b1) begin
         bad++;
         $display("[TB] FAIL wdt_halted: core_reset rose, expected 0 throughout");
      end
      auto_kick = 1'b1;
      ctrl_if.halt_button = 1'b1;
      repeat (7) tick();
      ctrl_if.halt_button = 1'b0;
      repeat (10) tick();
`else
      auto_kick = 1'b0;
      ok = 1'b1;
      repeat (60) begin
         tick();
         if (ctrl_if.core_reset !== 1'b0 || ctrl_if.reset_cause === 2'b10) ok = 1'b0;
      end
      auto_kick = 1'b1;
      total++;
      if (ok !== 1'b1) begin
         bad++;
         $display("[TB] FAIL no_wdt: core_reset=%b cause=%b, expected 0 and not 10", ctrl_if.core_reset, ctrl_if.reset_cause);
      end
      total++;
      if (ctrl_if.reset_cause !== 2'b01) begin
         bad++;
         $display("[TB] FAIL cause_held: got %b, expected 01", ctrl_if.reset_cause);
      end
`endif
   endtask

   task automatic test_async_reset();
      ctrl_if.reset_button = 1'b1;
      repeat (3) tick();
      #2;
      reset_n = 1'b0;
      #1;
      total++;
      if (ctrl_if.core_reset !== 1'b1) begin
         bad++;
         $display("[TB] FAIL async_debounce_reset: got %b, expected 1", ctrl_if.core_reset);
      end
      total++;
      if (ctrl_if.reset_cause !== 2'b00) begin
         bad++;
         $display("[TB] FAIL async_debounce_cause: got %b, expected 00", ctrl_if.reset_cause);
      end
      ctrl_if.reset_button = 1'b0;
      repeat (3) tick();
      por_sequence("async_debounce");

      ctrl_if.reset_button = 1'b1;
      repeat (10) tick();
      ctrl_if.reset_button = 1'b0;
      repeat (9) tick();
      total++;
      if (ctrl_if.reset_cause !== 2'b01) begin
         bad++;
         $display("[TB] FAIL hold_cause_before: got %b, expected 01", ctrl_if.reset_cause);
      end
      #2;
      reset_n = 1'b0;
      #1;
      total++;
      if (ctrl_if.core_reset !== 1'b1) begin
         bad++;
         $display("[TB] FAIL async_hold_reset: got %b, expected 1", ctrl_if.core_reset);
      end
      total++;
      if (ctrl_if.reset_cause !== 2'b00) begin
         bad++;
         $display("[TB] FAIL async_hold_cause: got %b, expected 00", ctrl_if.reset_cause);
      end
      repeat (3) tick();
      por_sequence("async_hold");
   endtask

   initial begin
      ctrl_if.reset_button = 1'b0;
      ctrl_if.halt_button  = 1'b0;
      $display("[TB] starting reset/halt controller bench");
      test_reset();
      test_reset_button();
      test_halt();
      test_simultaneous();
      test_watchdog();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
